// File: rtl/qdec_pkg.sv
// qdec_pkg: shared phase encodings, filter limits and step helpers for the
// quadrature step decoder.
package qdec_pkg;

    // Accepted {A,B} phase pair. Each encoding equals the pair it represents.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } phase_e;

    // Legal range of the glitch filter length.
    localparam int FILT_LEN_MIN = 2;
    localparam int FILT_LEN_MAX = 15;

    // Width of the filter run-length counter (holds FILT_LEN_MAX - 1).
    localparam int FILT_CNT_W = 4;

    // Flops in each input synchroniser.
    localparam int SYNC_STAGES = 2;

    // Phase pair reached by one up step: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic phase_e phase_up(input phase_e cur);
        phase_e nxt;
        unique case (cur)
            S00: nxt = S01;
            S01: nxt = S11;
            S11: nxt = S10;
            S10: nxt = S00;
        endcase
        return nxt;
    endfunction

    // Phase pair reached by one down step: 00 -> 10 -> 11 -> 01 -> 00.
    function automatic phase_e phase_down(input phase_e cur);
        phase_e nxt;
        unique case (cur)
            S00: nxt = S10;
            S10: nxt = S11;
            S11: nxt = S01;
            S01: nxt = S00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// quad_step_decoder_if: encoder inputs and counter-control outputs of the
// quadrature step decoder. The decoder takes the slave side.
interface quad_step_decoder_if;

    logic A;        // quadrature phase A, asynchronous
    logic B;        // quadrature phase B, asynchronous
    logic Z;        // index pulse, asynchronous
    logic err_clr;  // clears the sticky error flag
    logic up;       // one-cycle increment strobe
    logic down;     // one-cycle decrement strobe
    logic load;     // one-cycle load strobe on index
    logic dir;      // last valid direction, 1 = up
    logic err;      // sticky illegal-transition flag

    modport master (
        output A, B, Z, err_clr,
        input  up, down, load, dir, err
    );

    modport slave (
        input  A, B, Z, err_clr,
        output up, down, load, dir, err
    );

endinterface

// File: rtl/qdec_sync_filter.sv
// qdec_sync_filter: two-flop synchroniser for one asynchronous encoder input,
// followed by an optional run-length glitch filter.
// Build option: define QDEC_FILTER_EN to enable the filter; otherwise the
// synchronised level is passed straight through and FILT_LEN only gets
// its range checked.
module qdec_sync_filter
    import qdec_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta;
    logic sync;

    if (FILT_LEN < FILT_LEN_MIN || FILT_LEN > FILT_LEN_MAX) begin : g_bad_filt_len
        $error("qdec_sync_filter: FILT_LEN out of range");
    end

    // Two-flop synchroniser: the first stage may go metastable, the second
    // presents a settled level to the rest of the design.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the values present before the edge, whatever the statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

`ifdef QDEC_FILTER_EN
    localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);

    logic [FILT_CNT_W-1:0] run_cnt;
    logic                  acc;

    // Adopt the synchronised level only after FILT_LEN consecutive samples
    // that differ from the currently accepted level; any return resets the run.
    always_ff @(posedge CLK) begin
        if (RST) begin
            run_cnt <= '0;
            acc     <= 1'b0;
        end else if (sync == acc) begin
            run_cnt <= '0;
        end else if (run_cnt == CNT_LAST) begin
            run_cnt <= '0;
            acc     <= sync;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign q = acc;
`else
    assign q = sync;
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: turns asynchronous quadrature phases A/B and index Z
// into registered up/down/load strobes for an external counter, with a
// direction indicator and a sticky illegal-transition flag.
// Build option: define QDEC_FILTER_EN to put a FILT_LEN-sample glitch filter
// after each synchroniser (step latency 3 + FILT_LEN instead of 3).
module quad_step_decoder
    import qdec_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic                CLK,
    input  logic                RST,
    quad_step_decoder_if.slave  bus
);

    // Cycles after reset until the accepted inputs reflect the real pins.
`ifdef QDEC_FILTER_EN
    localparam int PRIME_LEN = SYNC_STAGES + FILT_LEN;
`else
    localparam int PRIME_LEN = SYNC_STAGES;
`endif
    localparam int              PRIME_W    = 5;
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_LEN);

    logic a_acc;
    logic b_acc;
    logic z_acc;

    qdec_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_a (
        .CLK (CLK),
        .RST (RST),
        .d   (bus.A),
        .q   (a_acc)
    );

    qdec_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_b (
        .CLK (CLK),
        .RST (RST),
        .d   (bus.B),
        .q   (b_acc)
    );

    qdec_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_z (
        .CLK (CLK),
        .RST (RST),
        .d   (bus.Z),
        .q   (z_acc)
    );

    phase_e             cur_pair;
    phase_e             state_q;
    phase_e             state_d;
    logic [PRIME_W-1:0] prime_cnt;
    logic               primed_q;
    logic               z_prev_q;

    logic step_up;
    logic step_dn;
    logic illegal;
    logic up_d;
    logic down_d;
    logic load_d;
    logic dir_d;
    logic err_d;

    logic up_q;
    logic down_q;
    logic load_q;
    logic dir_q;
    logic err_q;

    assign cur_pair = phase_e'({a_acc, b_acc});

    // Hold off decoding until the synchroniser/filter pipeline has been
    // refilled from the pins, so the first real pair becomes the start state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prime_cnt <= '0;
            primed_q  <= 1'b0;
        end else if (!primed_q) begin
            if (prime_cnt == PRIME_LAST) begin
                primed_q <= 1'b1;
            end else begin
                prime_cnt <= prime_cnt + 1'b1;
            end
        end
    end

    // Phase state register and previous accepted index level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S00;
            z_prev_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            z_prev_q <= z_acc;
        end
    end

    // Next phase state, step classification and strobe/flag next values.
    // NOTE: every variable gets a default before any branch so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        step_up = 1'b0;
        step_dn = 1'b0;
        illegal = 1'b0;

        if (!primed_q) begin
            state_d = cur_pair;
        end else if (cur_pair != state_q) begin
            state_d = cur_pair;
            if (cur_pair == phase_up(state_q)) begin
                step_up = 1'b1;
            end else if (cur_pair == phase_down(state_q)) begin
                step_dn = 1'b1;
            end else begin
                illegal = 1'b1;
            end
        end

        load_d = primed_q & z_acc & ~z_prev_q;
        // An index load takes priority over a step in the same cycle.
        up_d   = step_up & ~load_d;
        down_d = step_dn & ~load_d;

        dir_d = dir_q;
        if (step_up) begin
            dir_d = 1'b1;
        end else if (step_dn) begin
            dir_d = 1'b0;
        end

        // A new illegal transition wins over a simultaneous clear.
        err_d = illegal | (err_q & ~bus.err_clr);
    end

    // Registered strobes and flags; reset also discards any pending strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            load_q <= 1'b0;
            dir_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            up_q   <= up_d;
            down_q <= down_d;
            load_q <= load_d;
            dir_q  <= dir_d;
            err_q  <= err_d;
        end
    end

    assign bus.up   = up_q;
    assign bus.down = down_q;
    assign bus.load = load_q;
    assign bus.dir  = dir_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: directed bench for quad_step_decoder. Inputs change
// on the falling edge and outputs are sampled on later falling edges, so
// sample i is taken half a cycle after the i-th rising edge following a change.
module tb_quad_step_decoder;

    localparam int FILT = 4;
`ifdef QDEC_FILTER_EN
    localparam int LAT = 3 + FILT;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    quad_step_decoder_if bus ();

    quad_step_decoder #(.FILT_LEN(FILT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Reset state, then an idle period with all inputs low.
    task automatic test_reset();
        RST         = 1'b1;
        bus.A       = 1'b0;
        bus.B       = 1'b0;
        bus.Z       = 1'b0;
        bus.err_clr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            n_total++;
            if ({bus.up, bus.down, bus.load, bus.dir, bus.err} !== 5'b0)
                $display("FAIL reset_hold cyc%0d: outputs=%b expected 00000", i,
                         {bus.up, bus.down, bus.load, bus.dir, bus.err});
            else n_pass++;
        end
        RST = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            n_total++;
            if ({bus.up, bus.down, bus.load, bus.dir, bus.err} !== 5'b0)
                $display("FAIL reset_idle cyc%0d: outputs=%b expected 00000", i,
                         {bus.up, bus.down, bus.load, bus.dir, bus.err});
            else n_pass++;
        end
    endtask

    // 00 -> 01 -> 11 -> 10 -> 00: four up strobes, each LAT cycles after its edge.
    task automatic test_up_seq();
        logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        int ups = 0;
        for (int s = 0; s < 4; s++) begin
            {bus.A, bus.B} = seq[s];
            for (int i = 1; i <= HOLD; i++) begin
                logic exp_up;
                @(negedge CLK);
                exp_up = (i == LAT);
                n_total++;
                if (bus.up !== exp_up || bus.down !== 1'b0)
                    $display("FAIL up_seq step%0d cyc%0d: up=%b down=%b expected up=%b down=0",
                             s, i, bus.up, bus.down, exp_up);
                else n_pass++;
                if (bus.up === 1'b1) ups++;
            end
        end
        n_total++;
        if (ups != 4 || bus.dir !== 1'b1 || bus.err !== 1'b0)
            $display("FAIL up_seq_total: ups=%0d dir=%b err=%b expected ups=4 dir=1 err=0",
                     ups, bus.dir, bus.err);
        else n_pass++;
    endtask

    // 00 -> 10 -> 11 -> 01 -> 00: four down strobes, no up, dir ends 0.
    task automatic test_down_seq();
        logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        int downs = 0;
        for (int s = 0; s < 4; s++) begin
            {bus.A, bus.B} = seq[s];
            for (int i = 1; i <= HOLD; i++) begin
                logic exp_dn;
                @(negedge CLK);
                exp_dn = (i == LAT);
                n_total++;
                if (bus.down !== exp_dn || bus.up !== 1'b0)
                    $display("FAIL down_seq step%0d cyc%0d: down=%b up=%b expected down=%b up=0",
                             s, i, bus.down, bus.up, exp_dn);
                else n_pass++;
                if (bus.down === 1'b1) downs++;
            end
        end
        n_total++;
        if (downs != 4 || bus.dir !== 1'b0)
            $display("FAIL down_seq_total: downs=%0d dir=%b expected downs=4 dir=0",
                     downs, bus.dir);
        else n_pass++;
    endtask

    // Illegal jumps, err_clr, and set-wins when both land in the same cycle.
    task automatic test_illegal();
        // 00 -> 11: no strobe, err rises with the accepted change, dir stays 0.
        {bus.A, bus.B} = 2'b11;
        for (int i = 1; i <= HOLD; i++) begin
            logic exp_err;
            @(negedge CLK);
            exp_err = (i >= LAT);
            n_total++;
            if (bus.up !== 1'b0 || bus.down !== 1'b0 || bus.err !== exp_err || bus.dir !== 1'b0)
                $display("FAIL jump_00_11 cyc%0d: up=%b down=%b err=%b dir=%b expected 0 0 %b 0",
                         i, bus.up, bus.down, bus.err, bus.dir, exp_err);
            else n_pass++;
        end
        // One-cycle clear pulse.
        bus.err_clr = 1'b1;
        @(negedge CLK);
        bus.err_clr = 1'b0;
        n_total++;
        if (bus.err !== 1'b0)
            $display("FAIL err_clr: err=%b expected 0", bus.err);
        else n_pass++;
        // 11 -> 01 is a legal down step.
        {bus.A, bus.B} = 2'b01;
        for (int i = 1; i <= HOLD; i++) begin
            logic exp_dn;
            @(negedge CLK);
            exp_dn = (i == LAT);
            n_total++;
            if (bus.down !== exp_dn || bus.up !== 1'b0 || bus.err !== 1'b0)
                $display("FAIL step_11_01 cyc%0d: down=%b up=%b err=%b expected %b 0 0",
                         i, bus.down, bus.up, bus.err, exp_dn);
            else n_pass++;
        end
        // 01 -> 10 with err_clr high in the cycle the jump is registered.
        {bus.A, bus.B} = 2'b10;
        for (int i = 1; i <= HOLD; i++) begin
            logic exp_err;
            @(negedge CLK);
            exp_err = (i >= LAT);
            n_total++;
            if (bus.up !== 1'b0 || bus.down !== 1'b0 || bus.err !== exp_err || bus.dir !== 1'b0)
                $display("FAIL jump_01_10_clr cyc%0d: up=%b down=%b err=%b dir=%b expected 0 0 %b 0",
                         i, bus.up, bus.down, bus.err, bus.dir, exp_err);
            else n_pass++;
            bus.err_clr = (i == LAT - 1);
        end
        bus.err_clr = 1'b1;
        @(negedge CLK);
        bus.err_clr = 1'b0;
        // 10 -> 00 is a legal up step; lands at 00 with dir=1.
        {bus.A, bus.B} = 2'b00;
        for (int i = 1; i <= HOLD; i++) begin
            logic exp_up;
            @(negedge CLK);
            exp_up = (i == LAT);
            n_total++;
            if (bus.up !== exp_up || bus.err !== 1'b0)
                $display("FAIL step_10_00 cyc%0d: up=%b err=%b expected %b 0",
                         i, bus.up, bus.err, exp_up);
            else n_pass++;
        end
    endtask

    // Z rising together with a 00 -> 01 step: load only, up suppressed, dir updated.
    task automatic test_load_same_cycle();
        int loads = 0;
        // 00 -> 01 -> 00 leaves dir at 0.
        {bus.A, bus.B} = 2'b01;
        repeat (HOLD) @(negedge CLK);
        {bus.A, bus.B} = 2'b00;
        repeat (HOLD) @(negedge CLK);
        n_total++;
        if (bus.dir !== 1'b0)
            $display("FAIL load_pre_dir: dir=%b expected 0", bus.dir);
        else n_pass++;
        {bus.A, bus.B} = 2'b01;
        bus.Z = 1'b1;
        for (int i = 1; i <= HOLD; i++) begin
            logic exp_ld;
            @(negedge CLK);
            exp_ld = (i == LAT);
            n_total++;
            if (bus.load !== exp_ld || bus.up !== 1'b0 || bus.down !== 1'b0)
                $display("FAIL load_step cyc%0d: load=%b up=%b down=%b expected %b 0 0",
                         i, bus.load, bus.up, bus.down, exp_ld);
            else n_pass++;
            if (bus.load === 1'b1) loads++;
        end
        n_total++;
        if (loads != 1 || bus.dir !== 1'b1)
            $display("FAIL load_total: loads=%0d dir=%b expected loads=1 dir=1", loads, bus.dir);
        else n_pass++;
        bus.Z = 1'b0;
        for (int i = 1; i <= HOLD; i++) begin
            @(negedge CLK);
            n_total++;
            if (bus.load !== 1'b0)
                $display("FAIL load_fall cyc%0d: load=%b expected 0", i, bus.load);
            else n_pass++;
        end
    endtask

`ifdef QDEC_FILTER_EN
    // 2-cycle glitch on A is rejected; a 10-cycle A edge gives one up strobe.
    task automatic test_filter();
        int ups = 0;
        {bus.A, bus.B} = 2'b11;
        for (int i = 1; i <= 14; i++) begin
            @(negedge CLK);
            if (i == 2) {bus.A, bus.B} = 2'b01;
            n_total++;
            if (bus.up !== 1'b0 || bus.down !== 1'b0 || bus.err !== 1'b0)
                $display("FAIL filter_glitch cyc%0d: up=%b down=%b err=%b expected 0 0 0",
                         i, bus.up, bus.down, bus.err);
            else n_pass++;
        end
        {bus.A, bus.B} = 2'b11;
        for (int i = 1; i <= 10; i++) begin
            logic exp_up;
            @(negedge CLK);
            exp_up = (i == LAT);
            n_total++;
            if (bus.up !== exp_up || bus.down !== 1'b0)
                $display("FAIL filter_edge cyc%0d: up=%b down=%b expected %b 0",
                         i, bus.up, bus.down, exp_up);
            else n_pass++;
            if (bus.up === 1'b1) ups++;
        end
        n_total++;
        if (ups != 1)
            $display("FAIL filter_edge_total: ups=%0d expected 1", ups);
        else n_pass++;
    endtask
`endif

    // RST one cycle after an A edge: pending strobe dropped, outputs stay 0.
    task automatic test_reset_mid_step();
        bus.A = ~bus.A;
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            n_total++;
            if ({bus.up, bus.down, bus.load, bus.dir, bus.err} !== 5'b0)
                $display("FAIL mid_reset_hold cyc%0d: outputs=%b expected 00000", i,
                         {bus.up, bus.down, bus.load, bus.dir, bus.err});
            else n_pass++;
        end
        RST = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge CLK);
            n_total++;
            if ({bus.up, bus.down, bus.load, bus.dir, bus.err} !== 5'b0)
                $display("FAIL mid_reset_after cyc%0d: outputs=%b expected 00000", i,
                         {bus.up, bus.down, bus.load, bus.dir, bus.err});
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_up_seq();
        test_down_seq();
        test_illegal();
        test_load_same_cycle();
`ifdef QDEC_FILTER_EN
        test_filter();
`endif
        test_reset_mid_step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/quad_step_decoder.md
QUAD_STEP_DECODER -- requirements
Module: quad_step_decoder

Interface
REQ-001 SHALL have parameter FILT_LEN, default 4: consecutive stable samples a synchronised input needs before acceptance (range 2..15).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 SHALL have port RST  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port A  input  1  quadrature phase A; asynchronous to CLK.
REQ-005 SHALL have port B  input  1  quadrature phase B; asynchronous to CLK.
REQ-006 SHALL have port Z  input  1  index/home pulse; asynchronous to CLK.
REQ-007 SHALL have port err_clr  input  1  clears sticky err.
REQ-008 SHALL have port up  output  1  one-cycle increment strobe for an up/down counter.
REQ-009 SHALL have port down  output  1  one-cycle decrement strobe.
REQ-010 SHALL have port load  output  1  one-cycle load strobe on index.
REQ-011 SHALL have port dir  output  1  last valid direction: 1 = up, 0 = down.
REQ-012 SHALL have port err  output  1  sticky illegal-transition flag.

Function
REQ-013 SHALL pass A, B and Z each through a 2-flop synchroniser before any decoding.
REQ-014 SHALL hold the accepted phase pair {A,B} as a 4-state machine: S00, S01, S11, S10.
REQ-015 SHALL decode S00->S01->S11->S10->S00 as one up step per transition, and the reverse order as one down step per transition.
REQ-016 SHALL treat a change of both phase bits in one accepted sample as illegal: no strobe, err set, state moves to the new pair.
REQ-017 SHALL produce up, down and load as registered single-cycle pulses, one cycle after the accepted state change.
REQ-018 SHALL make step latency, from a stable edge on A or B to its strobe, 3 cycles without filtering.
REQ-019 SHALL emit load on the rising edge of the accepted Z, once per edge.
REQ-020 SHALL suppress up/down when load fires in the same cycle; the phase state still updates and dir still updates.
REQ-021 SHALL never assert up and down in the same cycle.
REQ-022 SHALL update dir only on a valid step; an illegal transition leaves dir unchanged.
REQ-023 SHALL clear err on err_clr; when an illegal transition and err_clr occur in the same cycle, err SHALL be 1 (set wins).

Reset
REQ-024 SHALL on RST clear up, down, load, dir and err to 0, and load the synchronisers and filters with 0.
REQ-025 SHALL take the first accepted phase pair after reset as the initial state without emitting a strobe or setting err.
REQ-026 SHALL on reset asserted mid-step discard the pending strobe; none is emitted after RST deasserts.

Configuration
REQ-027 SHALL use macro QDEC_FILTER_EN: when defined, each synchronised input is accepted only after FILT_LEN consecutive equal samples, and latency becomes 3+FILT_LEN cycles.
REQ-028 SHALL, with QDEC_FILTER_EN undefined, accept the synchronised inputs directly; FILT_LEN is then ignored.

Structure
REQ-029 SHALL place the state encodings (S00..S10) and the FILT_LEN bounds in shared package qdec_pkg.
REQ-030 SHALL implement synchroniser plus optional filter as sub-module qdec_sync_filter, instantiated three times (A, B, Z).

Verification
REQ-031 SHALL cover: filter off, A/B stepping 00,01,11,10,00 with each pair held 8 cycles -> exactly 4 up pulses, each 3 cycles after its edge, dir=1.
REQ-032 SHALL cover: reverse sequence 00,10,11,01,00 -> exactly 4 down pulses, dir=0, no up.
REQ-033 SHALL cover: jump 00->11 -> no strobe, err=1 next cycle; err_clr pulse -> err=0; err_clr together with a 01->10 jump -> err stays 1.
REQ-034 SHALL cover: Z rising in the same accepted cycle as a 00->01 step -> load=1, up=0, dir=1.
REQ-035 SHALL cover: QDEC_FILTER_EN with FILT_LEN=4, a 2-cycle glitch on A -> no strobe; a 10-cycle A edge -> one up strobe 7 cycles after the edge.
REQ-036 SHALL cover: RST asserted 1 cycle after an A edge -> no strobe after release; all outputs 0 during and after reset.
